// File: rtl/tlv5618_feeder.sv
// Sample FIFO + tick-paced command sequencer feeding a TLV5618 serial DAC driver.
// Define TLV5618_DUAL_CH_EN to issue a buffer write then an A write per tick.
module tlv5618_feeder #(
    parameter int unsigned SAMPLE_DIV   = 50,
    parameter int unsigned DONE_TIMEOUT = 1023,
    parameter logic        SPD          = 1'b1
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [9:0]  sample_data,
    input  logic        sample_valid,
    output logic        sample_ready,
    output logic [15:0] parallel_dac_data,
    output logic        start_flag,
    input  logic        set_done,
    input  logic        err_clr,
    output logic        underrun,
    output logic        late_tick,
    output logic        timeout_err
);

    localparam logic [15:0] TickLast = 16'(SAMPLE_DIV - 1);
    localparam logic [11:0] TmoLast  = 12'(DONE_TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StLoad, StStart, StWait} state_e;

    state_e      state_q, state_d;
    logic [9:0]  mem_q [4];
    logic [1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [2:0]  count_q, count_d;
    logic        ready_q, ready_d;
    logic [15:0] tick_cnt_q, tick_cnt_d;
    logic [11:0] tmr_q, tmr_d;
    logic [9:0]  samp_q, samp_d;
    logic [15:0] dac_q, dac_d;
    logic        start_q, start_d;
    logic        und_q, und_d, late_q, late_d, tmo_q, tmo_d;
    logic        push, pop, tick, und_set, late_set, tmo_set;
    logic [15:0] word;
`ifdef TLV5618_DUAL_CH_EN
    logic        second_q, second_d;
`endif

    always_comb begin
        push       = sample_valid && ready_q;
        tick       = (tick_cnt_q == TickLast);
        tick_cnt_d = tick ? 16'd0 : tick_cnt_q + 16'd1;
`ifdef TLV5618_DUAL_CH_EN
        word = second_q ? {1'b1, SPD, 2'b00, samp_q, 2'b00}
                        : {1'b0, SPD, 1'b0, 1'b1, ~samp_q, 2'b00};
`else
        word = {1'b1, SPD, 2'b00, samp_q, 2'b00};
`endif
        state_d  = state_q;
        samp_d   = samp_q;
        dac_d    = dac_q;
        start_d  = 1'b0;
        tmr_d    = tmr_q;
        pop      = 1'b0;
        und_set  = 1'b0;
        tmo_set  = 1'b0;
        late_set = tick && (state_q != StIdle);
`ifdef TLV5618_DUAL_CH_EN
        second_d = second_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (tick) begin
                    if (count_q != 3'd0) begin
                        pop     = 1'b1;
                        samp_d  = mem_q[rd_ptr_q];
                        state_d = StLoad;
`ifdef TLV5618_DUAL_CH_EN
                        second_d = 1'b0;
`endif
                    end else begin
                        und_set = 1'b1;
                    end
                end
            end
            StLoad: begin
                dac_d   = word;
                start_d = 1'b1;
                tmr_d   = 12'd0;
                state_d = StStart;
            end
            StStart: begin
                tmr_d   = tmr_q + 12'd1;
                state_d = StWait;
            end
            StWait: begin
                tmr_d = tmr_q + 12'd1;
                // tmr_q counts cycles since the start_flag cycle
                if (set_done || (tmr_q >= TmoLast)) begin
                    tmo_set = !set_done;
`ifdef TLV5618_DUAL_CH_EN
                    if (!second_q) begin
                        second_d = 1'b1;
                        state_d  = StLoad;
                    end else begin
                        state_d = StIdle;
                    end
`else
                    state_d = StIdle;
`endif
                end
            end
            default: state_d = StIdle;
        endcase

        wr_ptr_d = push ? wr_ptr_q + 2'd1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 2'd1 : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
        ready_d = (count_d != 3'd4);

        // A set event in the same cycle wins over err_clr
        und_d  = und_set  ? 1'b1 : (err_clr ? 1'b0 : und_q);
        late_d = late_set ? 1'b1 : (err_clr ? 1'b0 : late_q);
        tmo_d  = tmo_set  ? 1'b1 : (err_clr ? 1'b0 : tmo_q);
    end

    always_ff @(posedge sys_clk) begin
        if (push) mem_q[wr_ptr_q] <= sample_data;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= StIdle;
            wr_ptr_q   <= 2'd0;
            rd_ptr_q   <= 2'd0;
            count_q    <= 3'd0;
            ready_q    <= 1'b0;
            tick_cnt_q <= 16'd0;
            tmr_q      <= 12'd0;
            samp_q     <= 10'd0;
            dac_q      <= 16'h0000;
            start_q    <= 1'b0;
            und_q      <= 1'b0;
            late_q     <= 1'b0;
            tmo_q      <= 1'b0;
`ifdef TLV5618_DUAL_CH_EN
            second_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ready_q    <= ready_d;
            tick_cnt_q <= tick_cnt_d;
            tmr_q      <= tmr_d;
            samp_q     <= samp_d;
            dac_q      <= dac_d;
            start_q    <= start_d;
            und_q      <= und_d;
            late_q     <= late_d;
            tmo_q      <= tmo_d;
`ifdef TLV5618_DUAL_CH_EN
            second_q   <= second_d;
`endif
        end
    end

    assign sample_ready      = ready_q;
    assign parallel_dac_data = dac_q;
    assign start_flag        = start_q;
    assign underrun          = und_q;
    assign late_tick         = late_q;
    assign timeout_err       = tmo_q;

endmodule

// File: tb/tb_tlv5618_feeder.sv
// Directed bench: three instances (default, DONE_TIMEOUT=20, SAMPLE_DIV=30) with a
// set_done driver model per instance; dual-channel checks when TLV5618_DUAL_CH_EN is set.
module tb_tlv5618_feeder;

    localparam int DIVS [3] = '{50, 50, 30};
    localparam int TMOS [3] = '{1023, 20, 1023};

    logic        clk;
    logic        rst_n  [3];
    logic [9:0]  sdata  [3];
    logic        svalid [3];
    logic        sready [3];
    logic [15:0] dac    [3];
    logic        start  [3];
    logic        done   [3];
    logic        eclr   [3];
    logic        und    [3];
    logic        late   [3];
    logic        tmo    [3];
    int          dly    [3];
    int          cd     [3];
    int          nst    [3];
    int          ntests = 0;
    int          nfail  = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        tlv5618_feeder #(
            .SAMPLE_DIV  (DIVS[g]),
            .DONE_TIMEOUT(TMOS[g]),
            .SPD         (1'b1)
        ) u_dut (
            .sys_clk          (clk),
            .sys_rst_n        (rst_n[g]),
            .sample_data      (sdata[g]),
            .sample_valid     (svalid[g]),
            .sample_ready     (sready[g]),
            .parallel_dac_data(dac[g]),
            .start_flag       (start[g]),
            .set_done         (done[g]),
            .err_clr          (eclr[g]),
            .underrun         (und[g]),
            .late_tick        (late[g]),
            .timeout_err      (tmo[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Driver model: pulse set_done dly cycles after start_flag (dly 0 withholds it)
    initial begin
        for (int i = 0; i < 3; i++) begin
            done[i] = 1'b0;
            cd[i]   = 0;
            nst[i]  = 0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                done[i] = 1'b0;
                if (start[i]) begin
                    nst[i] = nst[i] + 1;
                    cd[i]  = dly[i];
                end else if (cd[i] > 0) begin
                    cd[i] = cd[i] - 1;
                    if (cd[i] == 0) done[i] = 1'b1;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish, required finish before 1ms");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset_vals(input int d, input string tag);
        check({tag, "_dac"},   32'(dac[d]),    32'h0);
        check({tag, "_start"}, 32'(start[d]),  32'h0);
        check({tag, "_ready"}, 32'(sready[d]), 32'h0);
        check({tag, "_flags"}, {29'd0, und[d], late[d], tmo[d]}, 32'h0);
    endtask

    task automatic do_reset(input int d, input string tag);
        rst_n[d]  = 1'b0;
        svalid[d] = 1'b0;
        eclr[d]   = 1'b0;
        sdata[d]  = 10'd0;
        cyc(2);
        check_reset_vals(d, tag);
        rst_n[d] = 1'b1;
        cyc(1);
        check({tag, "_ready_after"}, 32'(sready[d]), 32'h1);
    endtask

    task automatic push(input int d, input logic [9:0] v);
        sdata[d]  = v;
        svalid[d] = 1'b1;
        cyc(1);
        svalid[d] = 1'b0;
    endtask

    task automatic wait_start(input int d, input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (start[d]) break;
        end
        check({tag, "_start_seen"}, 32'(start[d]), 32'h1);
    endtask

    logic [9:0]  vals  [5];
    logic [15:0] words [5];
    int          snap;

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst_n[i]  = 1'b1;
            sdata[i]  = 10'd0;
            svalid[i] = 1'b0;
            eclr[i]   = 1'b0;
            dly[i]    = 0;
        end
        #2;
        for (int i = 0; i < 3; i++) rst_n[i] = 1'b0;

        // Single transfer of full-scale sample
        do_reset(0, "basic");
        dly[0] = 40;
        snap = nst[0];
        push(0, 10'h3FF);
        wait_start(0, 100, "basic");
        check("basic_word", 32'(dac[0]), 32'hCFFC);
        cyc(1);
        check("basic_pulse_width", 32'(start[0]), 32'h0);
        cyc(43);
        check("basic_nstart", 32'(nst[0] - snap), 32'h1);
        check("basic_flags", {29'd0, und[0], late[0], tmo[0]}, 32'h0);
        check("basic_word_stable", 32'(dac[0]), 32'hCFFC);

        // Underrun on empty FIFO, cleared by err_clr
        do_reset(0, "und");
        snap = nst[0];
        cyc(165);
        check("und_set", 32'(und[0]), 32'h1);
        check("und_nstart", 32'(nst[0] - snap), 32'h0);
        eclr[0] = 1'b1;
        cyc(1);
        eclr[0] = 1'b0;
        check("und_cleared", 32'(und[0]), 32'h0);

        // Timeout after 20 cycles, recovery, clear and set-over-clear priority
        do_reset(1, "tmo");
        dly[1] = 0;
        push(1, 10'h155);
        wait_start(1, 100, "tmo1");
        check("tmo_word1", 32'(dac[1]), 32'hC554);
        cyc(19);
        check("tmo_not_yet", 32'(tmo[1]), 32'h0);
        cyc(1);
        check("tmo_at_20", 32'(tmo[1]), 32'h1);
        push(1, 10'h2AA);
        wait_start(1, 60, "tmo2");
        check("tmo_word2", 32'(dac[1]), 32'hCAA8);
        check("tmo_no_late", 32'(late[1]), 32'h0);
        cyc(1);
        eclr[1] = 1'b1;
        cyc(1);
        eclr[1] = 1'b0;
        check("tmo_cleared", 32'(tmo[1]), 32'h0);
        cyc(17);
        eclr[1] = 1'b1;
        cyc(1);
        eclr[1] = 1'b0;
        check("tmo_set_beats_clr", 32'(tmo[1]), 32'h1);

        // Fill FIFO, hold fifth sample upstream, drain in order
        do_reset(0, "fifo");
        dly[0] = 10;
        vals[0] = 10'h001; vals[1] = 10'h123; vals[2] = 10'h2AA;
        vals[3] = 10'h3FE; vals[4] = 10'h055;
        words[0] = 16'hC004; words[1] = 16'hC48C; words[2] = 16'hCAA8;
        words[3] = 16'hCFF8; words[4] = 16'hC154;
        svalid[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sdata[0] = vals[i];
            cyc(1);
            if (i == 2) check("fifo_ready_3", 32'(sready[0]), 32'h1);
            if (i >= 3) check("fifo_full_ready", 32'(sready[0]), 32'h0);
        end
        wait_start(0, 100, "fifo0");
        check("fifo_word0", 32'(dac[0]), 32'(words[0]));
        check("fifo_refilled", 32'(sready[0]), 32'h0);
        svalid[0] = 1'b0;
        for (int i = 1; i < 5; i++) begin
            wait_start(0, 60, "fifo_n");
            check("fifo_word_n", 32'(dac[0]), 32'(words[i]));
        end
        check("fifo_no_late", 32'(late[0]), 32'h0);

        // Late tick with SAMPLE_DIV=30 and 40-cycle driver
        do_reset(2, "late");
        dly[2] = 40;
        push(2, 10'h0F0);
        push(2, 10'h30F);
        wait_start(2, 60, "late1");
        check("late_word1", 32'(dac[2]), 32'hC3C0);
        check("late_not_yet", 32'(late[2]), 32'h0);
        cyc(40);
        check("late_set", 32'(late[2]), 32'h1);
        wait_start(2, 40, "late2");
        check("late_word2", 32'(dac[2]), 32'hCC3C);
        check("late_no_und", 32'(und[2]), 32'h0);

        // Reset mid-transfer (second transfer when dual-channel)
        do_reset(0, "abort");
        dly[0] = 10;
        push(0, 10'h100);
        wait_start(0, 100, "abort1");
`ifdef TLV5618_DUAL_CH_EN
        check("dual_word_b", 32'(dac[0]), 32'h5BFC);
        wait_start(0, 30, "abort2");
`endif
        check("abort_word_a", 32'(dac[0]), 32'hC400);
        cyc(3);
        rst_n[0] = 1'b0;
        #1;
        check_reset_vals(0, "abort_rst");
        cyc(2);
        rst_n[0] = 1'b1;
        snap = nst[0];
        cyc(120);
        check("abort_no_start", 32'(nst[0] - snap), 32'h0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/tlv5618_feeder.md
TLV5618_FEEDER -- requirements
Module: tlv5618_feeder

Interface
REQ-001 SHALL have parameter SAMPLE_DIV, default 50: sys_clk cycles per sample tick, legal range 4..65535.
REQ-002 SHALL have parameter DONE_TIMEOUT, default 1023: maximum cycles to wait for set_done, legal range 1..4095.
REQ-003 SHALL have parameter SPD, default 1'b1: TLV5618 speed bit placed in D14 of every command word.
REQ-004 SHALL have port sys_clk, input, 1 bit: the single clock.
REQ-005 SHALL have port sys_rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port sample_data, input, 10 bits: waveform sample from the upstream wave generator.
REQ-007 SHALL have port sample_valid, input, 1 bit: sample_data is valid this cycle.
REQ-008 SHALL have port sample_ready, output, 1 bit: FIFO can accept a sample.
REQ-009 SHALL have port parallel_dac_data, output, 16 bits: command word to the tlv5618 serial driver.
REQ-010 SHALL have port start_flag, output, 1 bit: one-cycle transfer start pulse to the driver.
REQ-011 SHALL have port set_done, input, 1 bit: driver transfer-complete pulse.
REQ-012 SHALL have port err_clr, input, 1 bit: clears the sticky error flags.
REQ-013 SHALL have port underrun, output, 1 bit: sticky flag, a tick found the FIFO empty.
REQ-014 SHALL have port late_tick, output, 1 bit: sticky flag, a tick arrived while the FSM was not in IDLE.
REQ-015 SHALL have port timeout_err, output, 1 bit: sticky flag, set_done did not arrive within DONE_TIMEOUT cycles.

Function
REQ-016 SHALL hold a 4-entry sample FIFO; a push occurs when sample_valid and sample_ready are both 1; sample_ready SHALL be 1 when count<4.
REQ-017 SHALL generate a tick: a one-cycle pulse every SAMPLE_DIV cycles, the first tick SAMPLE_DIV cycles after reset release.
REQ-018 SHALL implement the FSM IDLE -> LOAD -> START -> WAIT -> IDLE.
REQ-019 IDLE: on a tick with the FIFO non-empty, SHALL pop one entry and go to LOAD; on a tick with the FIFO empty, SHALL set underrun and stay in IDLE.
REQ-020 LOAD: SHALL register the command word on parallel_dac_data; the word SHALL stay stable until the next LOAD.
REQ-021 START: SHALL assert start_flag for exactly 1 cycle, then go to WAIT.
REQ-022 WAIT: on set_done SHALL go to IDLE; if DONE_TIMEOUT cycles pass without set_done, SHALL set timeout_err and go to IDLE.
REQ-023 The channel-A word SHALL be {1'b1, SPD, 1'b0, 1'b0, s[9:0], 2'b00}, where s is the popped sample.
REQ-024 A tick in any state other than IDLE SHALL set late_tick; the tick is dropped, not queued.
REQ-025 A simultaneous push and pop SHALL leave count unchanged; a push when full SHALL be impossible because sample_ready is 0.
REQ-026 set_done outside WAIT SHALL be ignored.
REQ-027 err_clr SHALL clear all three flags; a same-cycle set event SHALL take priority over err_clr.
REQ-028 The FIFO pointers SHALL wrap modulo 4.

Reset
REQ-029 Reset SHALL act asynchronously: FSM to IDLE, FIFO emptied, tick counter to 0.
REQ-030 During reset: parallel_dac_data=16'h0000, start_flag=0, sample_ready=0, and all flags=0.
REQ-031 After reset release, sample_ready SHALL be 1.
REQ-032 Reset asserted mid-transfer SHALL abort the transfer with no further start_flag pulse.

Configuration
REQ-033 Macro TLV5618_DUAL_CH_EN, when defined, SHALL make each tick perform two transfers from the same popped sample.
REQ-034 First transfer (buffer write): {1'b0, SPD, 1'b0, 1'b1, ~s, 2'b00}.
REQ-035 Second transfer (A write plus B update): the REQ-023 word; the FSM SHALL go WAIT -> LOAD for the second word, then to IDLE.
REQ-036 The timeout SHALL apply per transfer.
REQ-037 Without the macro: a single A-word transfer per tick, as in REQ-018..REQ-023.

Verification
REQ-038 Push 10'h3FF, driver model returns set_done 40 cycles after start_flag -> parallel_dac_data=16'hCFFC, one start_flag pulse, no flags.
REQ-039 No samples pushed, run 3 ticks -> underrun=1, start_flag never asserted; pulse err_clr -> underrun=0.
REQ-040 set_done withheld, DONE_TIMEOUT=20 -> timeout_err=1 exactly 20 cycles after start_flag, FSM back in IDLE, next tick starts a new transfer.
REQ-041 Push 5 samples back-to-back with no ticks -> sample_ready=0 after the 4th push, 5th sample held upstream; FIFO drains 1 entry per tick in order.
REQ-042 SAMPLE_DIV=30, set_done 40 cycles after start_flag -> late_tick=1.
REQ-043 TLV5618_DUAL_CH_EN defined, push 10'h100 -> words 16'h5BFC then 16'hC400 on consecutive transfers; assert reset during the second WAIT -> outputs at reset values, no further start_flag.
